// File: rtl/pc4_seq_pkg.sv
// Shared opcodes, sequencer state encoding and the zero-flag opcode mask for the
// pc4 program sequencer.
package pc4_seq_pkg;

  localparam logic [3:0] OP_HALT = 4'b0000;
  localparam logic [3:0] OP_JZ   = 4'b1011;
  localparam logic [3:0] OP_CALL = 4'b1110;
  localparam logic [3:0] OP_RET  = 4'b1111;

  // One bit per opcode: ALU ops whose result updates zero_flag (1,2,5,7,8).
  localparam logic [15:0] ZERO_FLAG_OPS = 16'b0000_0001_1010_0110;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    FETCH  = 3'd1,
    DECODE = 3'd2,
    EXEC   = 3'd3,
    HALT   = 3'd4
  } state_t;

  function automatic logic sets_zero_flag(input logic [3:0] op);
    return ZERO_FLAG_OPS[op];
  endfunction

endpackage

// File: rtl/pc4_return_stack.sv
// Return-address LIFO for CALL/RET. Push is ignored when full and pop when empty;
// the caller decides what an overflow or underflow means.
module pc4_return_stack #(
  parameter int STACK_DEPTH = 4
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          push,
  input  logic                          pop,
  input  logic [3:0]                    push_data,
  output logic [3:0]                    top_data,
  output logic                          full,
  output logic                          empty,
  output logic [$clog2(STACK_DEPTH):0]  sp
);

  localparam int SPW = $clog2(STACK_DEPTH) + 1;
  localparam int IW  = SPW - 1;

  logic [3:0]     stk [STACK_DEPTH];
  logic [SPW-1:0] sp_m1;

  assign sp_m1    = sp - SPW'(1);
  assign full     = (sp == SPW'(STACK_DEPTH));
  assign empty    = (sp == '0);
  assign top_data = stk[sp_m1[IW-1:0]];

  always_ff @(posedge clk) begin
    if (rst) begin
      sp <= '0;
    end else if (push && !full) begin
      sp <= sp + SPW'(1);
    end else if (pop && !empty) begin
      sp <= sp_m1;
    end
  end

  // Entries carry no reset; only sp defines which ones are live.
  always_ff @(posedge clk) begin
    if (push && !full) begin
      stk[sp[IW-1:0]] <= push_data;
    end
  end

endmodule

// File: rtl/pc4_program_sequencer.sv
// Fetch/decode/issue controller for the 4-bit datapath: program memory, pc, return
// stack and zero flag, with JZ/CALL/RET/HALT resolved locally.
module pc4_program_sequencer
  import pc4_seq_pkg::*;
#(
  parameter int STACK_DEPTH = 4
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          prog_we,
  input  logic [3:0]                    prog_addr,
  input  logic [7:0]                    prog_data,
  input  logic                          run,
  output logic                          exec_valid,
  output logic [3:0]                    exec_instr,
  output logic [3:0]                    exec_addr,
  input  logic                          exec_done,
  input  logic [3:0]                    exec_result,
  output logic [3:0]                    pc,
  output logic                          zero_flag,
  output logic                          busy,
  output logic                          halted,
  output logic                          stack_err,
  output logic [2:0]                    dbg_state,
  output logic [$clog2(STACK_DEPTH):0]  dbg_sp
);

  localparam int PROG_WORDS = 16;
  localparam int SPW        = $clog2(STACK_DEPTH) + 1;

  state_t         state;
  logic [7:0]     mem [PROG_WORDS];
  logic [7:0]     ir;
  logic [3:0]     ir_op;
  logic [3:0]     ir_addr;
  logic [3:0]     pc_inc;
  logic [3:0]     stk_top;
  logic           stop_req;
  logic           keep_going;
  logic           stk_push;
  logic           stk_pop;
  logic           stk_full;
  logic           stk_empty;
  logic [SPW-1:0] sp;

  assign ir_op      = ir[7:4];
  assign ir_addr    = ir[3:0];
  assign pc_inc     = pc + 4'd1;
  // A run=0 seen at any point of the current instruction stops before the next fetch.
  assign keep_going = run && !stop_req;
  assign stk_push   = (state == DECODE) && (ir_op == OP_CALL) && !stk_full;
  assign stk_pop    = (state == DECODE) && (ir_op == OP_RET) && !stk_empty;

  assign busy      = (state == FETCH) || (state == DECODE) || (state == EXEC);
  assign halted    = (state == HALT);
  assign dbg_state = state;
  assign dbg_sp    = sp;

  pc4_return_stack #(
    .STACK_DEPTH(STACK_DEPTH)
  ) u_stack (
    .clk       (clk),
    .rst       (rst),
    .push      (stk_push),
    .pop       (stk_pop),
    .push_data (pc_inc),
    .top_data  (stk_top),
    .full      (stk_full),
    .empty     (stk_empty),
    .sp        (sp)
  );

  // Writes are accepted only while nothing is being fetched, so they never collide.
  always_ff @(posedge clk) begin
    if (prog_we && ((state == IDLE) || (state == HALT))) begin
      mem[prog_addr] <= prog_data;
    end
  end

  // Handshake: exec_valid rises together with exec_instr/exec_addr and all three hold
  // until the cycle exec_done is sampled high; exec_done while exec_valid=0 is ignored.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      pc         <= 4'd0;
      ir         <= 8'd0;
      zero_flag  <= 1'b0;
      stack_err  <= 1'b0;
      exec_valid <= 1'b0;
      exec_instr <= 4'd0;
      exec_addr  <= 4'd0;
      stop_req   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          stop_req <= 1'b0;
          if (run) state <= FETCH;
        end
        FETCH: begin
          if (!run) stop_req <= 1'b1;
          ir    <= mem[pc];
          state <= DECODE;
        end
        DECODE: begin
          if (!run) stop_req <= 1'b1;
          case (ir_op)
            OP_HALT: state <= HALT;
            OP_JZ: begin
              pc    <= zero_flag ? ir_addr : pc_inc;
              state <= keep_going ? FETCH : IDLE;
            end
            OP_CALL: begin
              if (stk_full) begin
                stack_err <= 1'b1;
                state     <= HALT;
              end else begin
                pc    <= ir_addr;
                state <= keep_going ? FETCH : IDLE;
              end
            end
            OP_RET: begin
              if (stk_empty) begin
                stack_err <= 1'b1;
                state     <= HALT;
              end else begin
                pc    <= stk_top;
                state <= keep_going ? FETCH : IDLE;
              end
            end
            default: begin
              exec_valid <= 1'b1;
              exec_instr <= ir_op;
              exec_addr  <= ir_addr;
              state      <= EXEC;
            end
          endcase
        end
        EXEC: begin
          if (!run) stop_req <= 1'b1;
          if (exec_done) begin
            exec_valid <= 1'b0;
            pc         <= pc_inc;
            if (sets_zero_flag(exec_instr)) zero_flag <= (exec_result == 4'd0);
            state      <= keep_going ? FETCH : IDLE;
          end
        end
        HALT: begin
          if (!run) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_pc4_program_sequencer.sv
// Directed bench for pc4_program_sequencer: table of small programs with expected
// fetch trace, issued ops and final flags, plus hand sequences for handshake corners.
module tb_pc4_program_sequencer;
  import pc4_seq_pkg::*;

  logic       clk = 1'b0;
  logic       rst;
  logic       prog_we;
  logic [3:0] prog_addr;
  logic [7:0] prog_data;
  logic       run;
  logic       exec_valid;
  logic [3:0] exec_instr;
  logic [3:0] exec_addr;
  logic       exec_done;
  logic [3:0] exec_result;
  logic [3:0] pc;
  logic       zero_flag;
  logic       busy;
  logic       halted;
  logic       stack_err;
  logic [2:0] dbg_state;
  logic [2:0] dbg_sp;

  always #5 clk = ~clk;

  pc4_program_sequencer #(.STACK_DEPTH(4)) dut (
    .clk         (clk),
    .rst         (rst),
    .prog_we     (prog_we),
    .prog_addr   (prog_addr),
    .prog_data   (prog_data),
    .run         (run),
    .exec_valid  (exec_valid),
    .exec_instr  (exec_instr),
    .exec_addr   (exec_addr),
    .exec_done   (exec_done),
    .exec_result (exec_result),
    .pc          (pc),
    .zero_flag   (zero_flag),
    .busy        (busy),
    .halted      (halted),
    .stack_err   (stack_err),
    .dbg_state   (dbg_state),
    .dbg_sp      (dbg_sp)
  );

  typedef struct {
    string            name;
    logic [15:0][7:0] prog;
    logic [7:0][3:0]  res;
    logic [7:0][3:0]  trace;
    int               ntrace;
    logic [7:0][7:0]  iss;
    int               niss;
    logic [3:0]       pc;
    logic             zero;
    logic             err;
    logic [2:0]       sp;
  } vec_t;

  int tests = 0;
  int fails = 0;

  logic [3:0] exp_q[$];
  logic [7:0] exp_iss_q[$];

  logic            dp_en = 1'b0;
  logic            mon_en = 1'b0;
  logic            auto_done;
  logic [3:0]      auto_result;
  logic            man_done = 1'b0;
  logic [3:0]      man_result = 4'd0;
  logic [7:0][3:0] res_list = '0;

  always_comb begin
    exec_done   = dp_en ? auto_done : man_done;
    exec_result = dp_en ? auto_result : man_result;
  end

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Datapath model: completes each issued op one cycle after valid.
  initial begin
    int res_idx;
    res_idx     = 0;
    auto_done   = 1'b0;
    auto_result = 4'd0;
    forever begin
      @(negedge clk);
      if (rst) res_idx = 0;
      if (dp_en && exec_valid && !auto_done) begin
        auto_done   = 1'b1;
        auto_result = res_list[res_idx[2:0]];
        res_idx++;
      end else begin
        auto_done = 1'b0;
      end
    end
  end

  // Scoreboard: every FETCH pc and every newly issued op is checked against the queues.
  initial begin
    logic prev_valid;
    prev_valid = 1'b0;
    forever begin
      @(negedge clk);
      if (mon_en && (dbg_state == FETCH)) begin
        if (exp_q.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL trace: unexpected fetch at pc %0h, expected none", pc);
        end else begin
          check("trace_pc", 8'(pc), 8'(exp_q.pop_front()));
        end
      end
      if (mon_en && exec_valid && !prev_valid) begin
        if (exp_iss_q.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL issue: unexpected op %0h%0h, expected none", exec_instr, exec_addr);
        end else begin
          check("issue_op", {exec_instr, exec_addr}, exp_iss_q.pop_front());
        end
      end
      prev_valid = exec_valid;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, expected $finish");
    $fatal(1, "watchdog");
  end

  task automatic do_reset();
    rst     = 1'b1;
    run     = 1'b0;
    prog_we = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic load_prog(input logic [15:0][7:0] p);
    for (int i = 0; i < 16; i++) begin
      prog_we   = 1'b1;
      prog_addr = 4'(i);
      prog_data = p[i];
      @(negedge clk);
    end
    prog_we = 1'b0;
  endtask

  task automatic wait_halt(input string name);
    int cyc;
    cyc = 0;
    while (!halted && cyc < 600) begin
      @(negedge clk);
      cyc++;
    end
    tests++;
    if (!halted) begin
      fails++;
      $display("FAIL %s: halted=%0b after %0d cycles, expected 1", name, halted, cyc);
    end
  endtask

  task automatic wait_valid(input string name);
    int cyc;
    cyc = 0;
    while (!exec_valid && cyc < 20) begin
      @(negedge clk);
      cyc++;
    end
    tests++;
    if (!exec_valid) begin
      fails++;
      $display("FAIL %s: exec_valid=%0b after %0d cycles, expected 1", name, exec_valid, cyc);
    end
  endtask

  task automatic exec_vec(input vec_t v);
    exp_q.delete();
    exp_iss_q.delete();
    for (int i = 0; i < v.ntrace; i++) exp_q.push_back(v.trace[i]);
    for (int i = 0; i < v.niss; i++) exp_iss_q.push_back(v.iss[i]);
    res_list = v.res;
    dp_en    = 1'b1;
    mon_en   = 1'b1;
    run      = 1'b1;
    wait_halt({v.name, ".halt"});
    mon_en = 1'b0;
    check({v.name, ".pc"}, 8'(pc), 8'(v.pc));
    check({v.name, ".zero"}, 8'(zero_flag), 8'(v.zero));
    check({v.name, ".stack_err"}, 8'(stack_err), 8'(v.err));
    check({v.name, ".sp"}, 8'(dbg_sp), 8'(v.sp));
    check({v.name, ".trace_left"}, 8'(exp_q.size()), 8'd0);
    check({v.name, ".issue_left"}, 8'(exp_iss_q.size()), 8'd0);
    run = 1'b0;
    repeat (2) @(negedge clk);
    check({v.name, ".halt_exit"}, 8'(halted), 8'd0);
    check({v.name, ".err_sticky"}, 8'(stack_err), 8'(v.err));
  endtask

  function automatic vec_t blank(input string name);
    vec_t v;
    v.name = name; v.prog = '0; v.res = '0; v.trace = '0; v.ntrace = 0;
    v.iss = '0; v.niss = 0; v.pc = 4'd0; v.zero = 1'b0; v.err = 1'b0; v.sp = 3'd0;
    return v;
  endfunction

  vec_t vecs[9];

  initial begin
    vec_t             v;
    logic [15:0][7:0] p;

    // Trace/result/issue lists are packed with entry 0 in the least significant slot.
    vecs[0] = blank("basic_alu");
    vecs[0].prog[0] = 8'h10; vecs[0].res = 32'h0;
    vecs[0].trace = 32'h10; vecs[0].ntrace = 2; vecs[0].iss = 64'h10; vecs[0].niss = 1;
    vecs[0].pc = 4'd1; vecs[0].zero = 1'b1;

    vecs[1] = blank("jz_taken");
    vecs[1].prog[0] = 8'h20; vecs[1].prog[1] = 8'hB5; vecs[1].res = 32'h0;
    vecs[1].trace = 32'h510; vecs[1].ntrace = 3; vecs[1].iss = 64'h20; vecs[1].niss = 1;
    vecs[1].pc = 4'd5; vecs[1].zero = 1'b1;

    vecs[2] = blank("jz_not_taken");
    vecs[2].prog[0] = 8'h20; vecs[2].prog[1] = 8'hB5; vecs[2].res = 32'h3;
    vecs[2].trace = 32'h210; vecs[2].ntrace = 3; vecs[2].iss = 64'h20; vecs[2].niss = 1;
    vecs[2].pc = 4'd2; vecs[2].zero = 1'b0;

    vecs[3] = blank("call_ret");
    vecs[3].prog[0] = 8'hE4; vecs[3].prog[4] = 8'hF0;
    vecs[3].trace = 32'h140; vecs[3].ntrace = 3; vecs[3].pc = 4'd1;

    vecs[4] = blank("call_overflow");
    vecs[4].prog[0] = 8'hE0;
    vecs[4].trace = 32'h0; vecs[4].ntrace = 5; vecs[4].pc = 4'd0;
    vecs[4].err = 1'b1; vecs[4].sp = 3'd4;

    vecs[5] = blank("ret_underflow");
    vecs[5].prog[0] = 8'hF0;
    vecs[5].trace = 32'h0; vecs[5].ntrace = 1; vecs[5].pc = 4'd0; vecs[5].err = 1'b1;

    vecs[6] = blank("pc_wrap_call15");
    vecs[6].prog[0] = 8'h10; vecs[6].prog[1] = 8'hBF; vecs[6].prog[15] = 8'hE5;
    vecs[6].prog[5] = 8'hF0; vecs[6].res = 32'h30;
    vecs[6].trace = 32'h0210_5F10; vecs[6].ntrace = 7; vecs[6].iss = 64'h1010; vecs[6].niss = 2;
    vecs[6].pc = 4'd2; vecs[6].zero = 1'b0;

    vecs[7] = blank("flag_kept_op3");
    vecs[7].prog[0] = 8'h10; vecs[7].prog[1] = 8'h3C; vecs[7].res = 32'h50;
    vecs[7].trace = 32'h210; vecs[7].ntrace = 3; vecs[7].iss = 64'h3C10; vecs[7].niss = 2;
    vecs[7].pc = 4'd2; vecs[7].zero = 1'b1;

    vecs[8] = blank("flag_mask");
    vecs[8].prog[0] = 8'h50; vecs[8].prog[1] = 8'h77; vecs[8].prog[2] = 8'hC3;
    vecs[8].res = 32'h090;
    vecs[8].trace = 32'h3210; vecs[8].ntrace = 4; vecs[8].iss = 64'hC37750; vecs[8].niss = 3;
    vecs[8].pc = 4'd3; vecs[8].zero = 1'b0;

    rst = 1'b1; run = 1'b0; prog_we = 1'b0; prog_addr = 4'd0; prog_data = 8'd0;
    do_reset();
    check("rst.pc", 8'(pc), 8'd0);
    check("rst.state", 8'(dbg_state), 8'(IDLE));
    check("rst.exec_valid", 8'(exec_valid), 8'd0);
    check("rst.exec_op", {exec_instr, exec_addr}, 8'h00);
    check("rst.flags", {4'd0, zero_flag, stack_err, busy, halted}, 8'h00);
    check("rst.sp", 8'(dbg_sp), 8'd0);

    for (int i = 0; i < 9; i++) begin
      do_reset();
      load_prog(vecs[i].prog);
      exec_vec(vecs[i]);
    end

    // Slow datapath: operands hold while done is low; prog_we during EXEC is dropped.
    do_reset();
    p = '0; p[0] = 8'h4A;
    load_prog(p);
    dp_en = 1'b0; man_done = 1'b0; man_result = 4'd0; run = 1'b1;
    wait_valid("stall.valid");
    prog_we = 1'b1; prog_addr = 4'd1; prog_data = 8'h2F;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      prog_we = 1'b0;
      check("stall.valid_hold", 8'(exec_valid), 8'd1);
      check("stall.op_hold", {exec_instr, exec_addr}, 8'h4A);
      check("stall.pc_hold", 8'(pc), 8'd0);
      check("stall.busy", 8'(busy), 8'd1);
    end
    man_done = 1'b1;
    @(negedge clk);
    man_done = 1'b0;
    check("stall.valid_drop", 8'(exec_valid), 8'd0);
    check("stall.pc_after_done", 8'(pc), 8'd1);
    check("stall.zero_op4", 8'(zero_flag), 8'd0);
    wait_halt("stall.halt");
    check("stall.we_ignored_pc", 8'(pc), 8'd1);

    // Reset while an op is outstanding, then rerun from the untouched program.
    run = 1'b0;
    do_reset();
    run = 1'b1;
    wait_valid("rst_exec.valid");
    rst = 1'b1;
    @(negedge clk);
    check("rst_exec.valid", 8'(exec_valid), 8'd0);
    check("rst_exec.pc", 8'(pc), 8'd0);
    check("rst_exec.state", 8'(dbg_state), 8'(IDLE));
    check("rst_exec.busy", 8'(busy), 8'd0);
    run = 1'b0;
    rst = 1'b0;
    @(negedge clk);
    v = blank("rerun");
    v.trace = 32'h10; v.ntrace = 2; v.iss = 64'h4A; v.niss = 1; v.pc = 4'd1;
    exec_vec(v);

    // run drops mid-op: op completes, sequencer parks in IDLE, then resumes.
    do_reset();
    p = '0; p[0] = 8'h10;
    load_prog(p);
    dp_en = 1'b0; man_done = 1'b0; run = 1'b1;
    wait_valid("pause.valid");
    run = 1'b0;
    repeat (2) @(negedge clk);
    check("pause.valid_hold", 8'(exec_valid), 8'd1);
    man_result = 4'd0; man_done = 1'b1;
    @(negedge clk);
    man_done = 1'b0;
    check("pause.state", 8'(dbg_state), 8'(IDLE));
    check("pause.pc", 8'(pc), 8'd1);
    check("pause.zero", 8'(zero_flag), 8'd1);
    check("pause.valid_drop", 8'(exec_valid), 8'd0);
    man_result = 4'd5; man_done = 1'b1;
    repeat (2) @(negedge clk);
    man_done = 1'b0;
    check("idle_done.pc", 8'(pc), 8'd1);
    check("idle_done.zero", 8'(zero_flag), 8'd1);
    check("idle_done.state", 8'(dbg_state), 8'(IDLE));
    run = 1'b1;
    wait_halt("resume.halt");
    check("resume.pc", 8'(pc), 8'd1);
    run = 1'b0;
    @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
